// File: rtl/dig_ct_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dig_ct_bist_ctrl
//  Purpose  : Exhaustive BIST sweep controller for the 5-input / 3-output
//             DigCt datapath. Applies all 32 input vectors in order, waits
//             WAIT_CYC cycles per vector, compares the datapath response
//             against the golden function and records the mismatch count and
//             the first failing vector.
//  Ports    : clk      - rising-edge clock (shared with the datapath)
//             rst      - synchronous active-high reset
//             start    - single-cycle sweep request (honoured in IDLE only)
//             abort    - terminates a running sweep
//             vec      - registered stimulus {IN5,IN4,IN3,IN2,IN1}
//             rsp      - registered datapath response {OUT3,OUT2,OUT1}
//             busy     - sweep in progress
//             done     - one-cycle pulse when a sweep completes
//             pass     - last completed sweep had no mismatches
//             err_cnt  - number of mismatching vectors (0..32)
//             fail_vld - fail_vec holds a captured failing vector
//             fail_vec - first vector that mismatched
//  Revision : 1.0 - initial release
// ============================================================================
module dig_ct_bist_ctrl #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic [4:0] vec,
    input  logic [2:0] rsp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_cnt,
    output logic       fail_vld,
    output logic [4:0] fail_vec
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_APPLY = 3'd1,
        S_HOLD  = 3'd2,
        S_CHECK = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    localparam logic [4:0] c_last_vec  = 5'd31;
    // HOLD occupies WAIT_CYC-1 cycles; the counter runs 1..c_hold_last.
    localparam logic [3:0] c_hold_last = 4'(WAIT_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_hold_cnt;
    logic [2:0] w_exp;
    logic       w_mismatch;
    logic       w_check;
    logic [5:0] w_err_nxt;

    // Golden DigCt response for the vector currently driven.
    assign w_exp[0] = ~(~(vec[0] | vec[1]) & vec[2]);
    assign w_exp[1] = ~(vec[1] & vec[2]);
    assign w_exp[2] = vec[2] | ~vec[3] | vec[4];

    assign w_mismatch = (rsp != w_exp);
    // An abort in CHECK discards that cycle's comparison.
    assign w_check    = (r_state == S_CHECK) && !abort;
    assign w_err_nxt  = err_cnt + {5'd0, w_mismatch};

    assign busy = (r_state == S_APPLY) || (r_state == S_HOLD) || (r_state == S_CHECK);
    assign done = (r_state == S_FIN);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_APPLY: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (WAIT_CYC == 1) begin
                    w_state_nxt = S_CHECK;
                end else begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (r_hold_cnt == c_hold_last) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (vec == c_last_vec) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_APPLY;
                end
            end
            S_FIN: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Hold-cycle counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold_cnt <= 4'd0;
        end else if (r_state == S_APPLY) begin
            r_hold_cnt <= 4'd1;
        end else if (r_state == S_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus and result registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vec      <= 5'd0;
            pass     <= 1'b0;
            err_cnt  <= 6'd0;
            fail_vld <= 1'b0;
            fail_vec <= 5'd0;
        end else if ((r_state == S_IDLE) && start && !abort) begin
            vec      <= 5'd0;
            pass     <= 1'b0;
            err_cnt  <= 6'd0;
            fail_vld <= 1'b0;
            fail_vec <= 5'd0;
        end else if (busy && abort) begin
            // Results so far are kept for diagnosis; the sweep never passes.
            pass <= 1'b0;
        end else if (w_check) begin
            if (w_mismatch) begin
                err_cnt <= w_err_nxt;
                if (!fail_vld) begin
                    fail_vec <= vec;
                    fail_vld <= 1'b1;
                end
            end
            if (vec == c_last_vec) begin
                // Verdict includes the final vector's own comparison.
                pass <= (w_err_nxt == 6'd0);
            end else begin
                vec <= vec + 5'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dig_ct_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dig_ct_bist_ctrl
//  Purpose  : Self-checking bench for dig_ct_bist_ctrl. Two controllers
//             (WAIT_CYC=1 and WAIT_CYC=3) share start/abort/rst and each
//             drives its own behavioural DigCt datapath with a pipeline depth
//             matching its wait time. Faults are modelled as a per-vector XOR
//             mask on the golden response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dig_ct_bist_ctrl;

    localparam int c_lat_a = 64;
    localparam int c_lat_b = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, abort;
    logic [4:0] vec_a, vec_b, fvec_a, fvec_b;
    logic [2:0] rsp_a, rsp_b, p1_b, p2_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fvld_a, fvld_b;
    logic [5:0] err_a, err_b;

    dig_ct_bist_ctrl #(.WAIT_CYC(1)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec_a), .rsp(rsp_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a),
        .fail_vld(fvld_a), .fail_vec(fvec_a)
    );

    dig_ct_bist_ctrl #(.WAIT_CYC(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .vec(vec_b), .rsp(rsp_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b),
        .fail_vld(fvld_b), .fail_vec(fvec_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [2:0] mask [32];

    typedef struct {
        int start_cyc;
        int lat;
        int err;
        int fvec;
        int fvld;
        int pass;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t it_a, it_b;
    int   bcnt_a = 0;
    int   bcnt_b = 0;
    int   last_err, last_pass;

    function automatic logic [2:0] e_of(input logic [4:0] v);
        logic [2:0] e;
        e[0] = ~(~(v[0] | v[1]) & v[2]);
        e[1] = ~(v[1] & v[2]);
        e[2] = v[2] | ~v[3] | v[4];
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Behavioural datapaths: 1 register stage for A, 3 stages for B.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rsp_a <= e_of(vec_a) ^ mask[vec_a];
        p1_b  <= e_of(vec_b) ^ mask[vec_b];
        p2_b  <= p1_b;
        rsp_b <= p2_b;
    end

    // Monitors: pop an expectation whenever a controller reports done.
    always @(negedge clk) begin
        if (busy_a) bcnt_a++;
        else if (!done_a) bcnt_a = 0;
        if (done_a) begin
            if (q_a.size() == 0) begin
                chk("A unexpected done", 1, 0);
            end else begin
                it_a = q_a.pop_front();
                chk("A done latency", cyc - it_a.start_cyc, it_a.lat);
                chk("A busy cycles", bcnt_a, it_a.lat);
                chk("A err_cnt", int'(err_a), it_a.err);
                chk("A fail_vld", int'(fvld_a), it_a.fvld);
                chk("A fail_vec", int'(fvec_a), it_a.fvec);
                chk("A pass", int'(pass_a), it_a.pass);
                chk("A vec final", int'(vec_a), 31);
                chk("A busy at done", int'(busy_a), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (busy_b) bcnt_b++;
        else if (!done_b) bcnt_b = 0;
        if (done_b) begin
            if (q_b.size() == 0) begin
                chk("B unexpected done", 1, 0);
            end else begin
                it_b = q_b.pop_front();
                chk("B done latency", cyc - it_b.start_cyc, it_b.lat);
                chk("B busy cycles", bcnt_b, it_b.lat);
                chk("B err_cnt", int'(err_b), it_b.err);
                chk("B fail_vld", int'(fvld_b), it_b.fvld);
                chk("B fail_vec", int'(fvec_b), it_b.fvec);
                chk("B pass", int'(pass_b), it_b.pass);
                chk("B vec final", int'(vec_b), 31);
            end
        end
    end

    // Mode 0 fault-free, 1 OUT3 stuck-at-0, 2 OUT2 inverted,
    // 3 random sparse faults, 4 random stuck-at on a random output.
    task automatic set_mask(input int mode);
        int         b;
        logic       s;
        logic [2:0] e, m;
        b = $urandom_range(0, 2);
        s = 1'($urandom_range(0, 1));
        for (int v = 0; v < 32; v++) begin
            e = e_of(5'(v));
            m = 3'b000;
            case (mode)
                1: m[2] = e[2];
                2: m = 3'b010;
                3: if ($urandom_range(0, 3) == 0) m = 3'($urandom_range(1, 7));
                4: m[b] = e[b] ^ s;
                default: m = 3'b000;
            endcase
            mask[v] = m;
        end
    endtask

    // Reference results over the first nvec vectors of a sweep.
    task automatic build_exp(input int nvec, output int err, output int fvec, output int fvld);
        err = 0; fvec = 0; fvld = 0;
        for (int v = 0; v < nvec; v++) begin
            if (mask[v] != 3'b000) begin
                err++;
                if (fvld == 0) begin
                    fvld = 1;
                    fvec = v;
                end
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_sweep(input int mode);
        exp_t x;
        int   err, fvec, fvld, n;
        set_mask(mode);
        build_exp(32, err, fvec, fvld);
        pulse_start();
        x.start_cyc = cyc;
        x.err = err; x.fvec = fvec; x.fvld = fvld; x.pass = (err == 0) ? 1 : 0;
        x.lat = c_lat_a; q_a.push_back(x);
        x.lat = c_lat_b; q_b.push_back(x);
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q_a.size() != 0 || q_b.size() != 0) begin
            chk("sweep timeout", q_a.size() + q_b.size(), 0);
            q_a.delete();
            q_b.delete();
        end
        last_err  = err;
        last_pass = x.pass;
        // Results must hold while idle.
        repeat (4) @(negedge clk);
        chk("A hold err_cnt", int'(err_a), err);
        chk("A hold pass", int'(pass_a), x.pass);
        chk("B hold err_cnt", int'(err_b), err);
        chk("B hold fail_vec", int'(fvec_b), fvec);
    endtask

    // Start, then drive the edge-numbered controls up to edge e after accept.
    task automatic run_until(input int e, input bit use_rst);
        pulse_start();
        for (int k = 1; k <= e; k++) begin
            start = (k == 3 || k == 5);
            abort = !use_rst && (k == e);
            rst   = use_rst && (k == e);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic abort_test(input int e);
        int err, fvec, fvld;
        set_mask(3);
        run_until(e, 1'b0);
        // Only vectors whose CHECK edge precedes the abort edge are counted.
        build_exp((e - 1) / 2, err, fvec, fvld);
        chk("A abort busy", int'(busy_a), 0);
        chk("A abort done", int'(done_a), 0);
        chk("A abort pass", int'(pass_a), 0);
        chk("A abort err_cnt", int'(err_a), err);
        chk("A abort fail_vld", int'(fvld_a), fvld);
        chk("A abort fail_vec", int'(fvec_a), fvec);
        build_exp((e - 1) / 4, err, fvec, fvld);
        chk("B abort busy", int'(busy_b), 0);
        chk("B abort pass", int'(pass_b), 0);
        chk("B abort err_cnt", int'(err_b), err);
        chk("B abort fail_vld", int'(fvld_b), fvld);
        chk("B abort fail_vec", int'(fvec_b), fvec);
        // Any done in this window is flagged by the monitors.
        repeat (140) @(negedge clk);
        chk("A idle after abort", int'(busy_a), 0);
    endtask

    task automatic reset_test(input int e);
        set_mask(2);
        run_until(e, 1'b1);
        chk("A rst vec", int'(vec_a), 0);
        chk("A rst busy", int'(busy_a), 0);
        chk("A rst done", int'(done_a), 0);
        chk("A rst pass", int'(pass_a), 0);
        chk("A rst err_cnt", int'(err_a), 0);
        chk("A rst fail_vld", int'(fvld_a), 0);
        chk("A rst fail_vec", int'(fvec_a), 0);
        chk("B rst vec", int'(vec_b), 0);
        chk("B rst busy", int'(busy_b), 0);
        chk("B rst err_cnt", int'(err_b), 0);
        chk("B rst fail_vld", int'(fvld_b), 0);
        repeat (140) @(negedge clk);
        run_sweep(0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        for (int v = 0; v < 32; v++) mask[v] = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset vec", int'(vec_a), 0);
        chk("reset busy", int'(busy_a), 0);
        chk("reset done", int'(done_a), 0);
        chk("reset pass", int'(pass_a), 0);
        chk("reset err_cnt", int'(err_a), 0);
        chk("reset fail_vld", int'(fvld_a), 0);
        rst = 1'b0;
        @(negedge clk);

        run_sweep(0);
        run_sweep(1);
        // START together with ABORT in IDLE is ignored; results are retained.
        @(negedge clk) begin start = 1'b1; abort = 1'b1; end
        @(negedge clk) begin start = 1'b0; abort = 1'b0; end
        repeat (3) @(negedge clk);
        chk("start+abort busy A", int'(busy_a), 0);
        chk("start+abort busy B", int'(busy_b), 0);
        chk("start+abort err kept", int'(err_a), last_err);
        chk("start+abort pass kept", int'(pass_a), last_pass);
        run_sweep(2);
        abort_test(10);
        reset_test(20);
        for (int i = 0; i < 6; i++) run_sweep($urandom_range(0, 4));
        abort_test($urandom_range(1, 60));
        reset_test($urandom_range(2, 60));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dig_ct_bist_ctrl.md
DIG_CT_BIST_CTRL -- requirements
Module: dig_ct_bist_ctrl

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYC, default 1, number of cycles from the applied vector to the response check (legal range 1..15).
REQ-002 The block SHALL have one clock and one reset: CLK and RST. Reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock, shared with the 3-output DigCt datapath.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 START  input  1  single-cycle request to begin a sweep.
REQ-006 ABORT  input  1  terminates a running sweep.
REQ-007 VEC  output  5  registered stimulus to the datapath: VEC[0]=IN1, VEC[1]=IN2, VEC[2]=IN3, VEC[3]=IN4, VEC[4]=IN5.
REQ-008 RSP  input  3  registered datapath response: RSP[0]=OUT1, RSP[1]=OUT2, RSP[2]=OUT3.
REQ-009 BUSY  output  1  high while a sweep runs.
REQ-010 DONE  output  1  one-cycle pulse at sweep completion.
REQ-011 PASS  output  1  high when the last completed sweep had zero mismatches.
REQ-012 ERR_CNT  output  6  count of mismatching vectors, range 0..32.
REQ-013 FAIL_VLD  output  1  high when FAIL_VEC holds a captured failing vector.
REQ-014 FAIL_VEC  output  5  first vector that mismatched.

Function
REQ-015 The block SHALL compute the expected response E from VEC as follows:
- E[0] = NOT(NOT(IN1 OR IN2) AND IN3)
- E[1] = NOT(IN2 AND IN3)
- E[2] = IN3 OR NOT IN4 OR IN5
REQ-016 The FSM SHALL have the states IDLE, APPLY, HOLD, CHECK and FIN.
REQ-017 In IDLE, START=1 with ABORT=0 SHALL, at that edge:
- enter APPLY
- set VEC=0 and BUSY=1
- clear ERR_CNT, FAIL_VLD, FAIL_VEC and PASS
REQ-018 APPLY SHALL last 1 cycle, then enter HOLD for WAIT_CYC-1 cycles (skipped when WAIT_CYC=1), then enter CHECK for 1 cycle; each vector therefore occupies WAIT_CYC+1 cycles.
REQ-019 VEC SHALL remain stable from APPLY through CHECK of the same vector.
REQ-020 In CHECK, RSP SHALL be compared against E(VEC). On a mismatch in any bit:
- ERR_CNT increments by 1 (once per vector, not per bit)
- if FAIL_VLD=0: FAIL_VEC<=VEC and FAIL_VLD<=1
REQ-021 After CHECK, if VEC<31: VEC increments and the FSM returns to APPLY. If VEC=31: the FSM enters FIN and VEC holds 31 (no wrap-around).
REQ-022 FIN SHALL last exactly 1 cycle, with DONE=1 and BUSY=0. PASS SHALL be set to 1 in FIN when the final ERR_CNT=0 (including the last vector's result). The FSM then returns to IDLE.
REQ-023 PASS, ERR_CNT, FAIL_VLD and FAIL_VEC SHALL hold their values in IDLE until the next accepted START.
REQ-024 START SHALL be ignored outside IDLE.
REQ-025 ABORT=1 in APPLY, HOLD or CHECK SHALL, at that edge:
- go to IDLE with BUSY=0 and PASS=0
- pulse no DONE
- retain ERR_CNT, FAIL_VLD and FAIL_VEC
- discard the comparison of the current cycle
REQ-026 START and ABORT high together in IDLE SHALL be ignored.
REQ-027 ERR_CNT SHALL NOT exceed 32; no saturation logic is required.
REQ-028 With WAIT_CYC=1, DONE SHALL assert exactly 64 cycles after the edge that accepted START.

Reset
REQ-029 RST=1 at a rising edge SHALL force, from any state including mid-sweep:
- the FSM to IDLE
- VEC=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VLD=0, FAIL_VEC=0
REQ-030 RST SHALL take priority over START and ABORT.

Verification
REQ-031 Scenario: fault-free DigCt attached, WAIT_CYC=1, START pulse -> BUSY high for 64 cycles, DONE at cycle 64, PASS=1, ERR_CNT=0, FAIL_VLD=0.
REQ-032 Scenario: OUT3 stuck-at-0 -> ERR_CNT=28, FAIL_VEC=5'b00000, PASS=0.
REQ-033 Scenario: OUT2 inverted -> ERR_CNT=32, FAIL_VEC=0, PASS=0. Repeat with WAIT_CYC=3 (datapath delayed 2 extra stages) -> DONE at cycle 128, same counts.
REQ-034 Scenario: ABORT at cycle 10 of a fault-free sweep -> BUSY=0 next cycle, DONE never asserts, PASS=0. START pulses at cycles 3 and 5 are ignored.
REQ-035 Scenario: RST at cycle 20 of a faulty sweep -> all outputs at reset values after that edge. A following START runs a full 64-cycle sweep.
